// File: rtl/sr_latch.sv
// rtl/sr_latch.sv - gated set/reset flag register with complementary outputs and conflict pulse
//
// Purpose:
//   WIDTH independent SR storage bits. Every bit updates only on the rising
//   clock edge, and only when enable is high. Simultaneous set and reset on a
//   bit is resolved by CONFLICT_MODE. The conflict output pulses for one cycle
//   when any enabled bit sees both requests at once.
//
// Parameters:
//   WIDTH          number of independent SR bits
//   CONFLICT_MODE  s=r=1 response: 0 hold, 1 set wins, 2 reset wins, 3+ hold
//   RESET_VALUE    value loaded into q on reset (qbar loads its inverse)
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset, overrides everything
//   enable    in   1      gate for s/r
//   s         in   WIDTH  per-bit set request
//   r         in   WIDTH  per-bit reset request
//   q         out  WIDTH  stored state
//   qbar      out  WIDTH  registered complement of q
//   conflict  out  1      one-cycle pulse: some enabled bit saw s=r=1

module sr_latch #(
    parameter int               WIDTH         = 1,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             conflict
);

    // Out-of-range modes fold onto hold.
    localparam bit SET_WINS   = (CONFLICT_MODE == 1);
    localparam bit RESET_WINS = (CONFLICT_MODE == 2);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qbar_q;
    logic             conflict_q;
    logic             conflict_d;

    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] set_only;
    logic [WIDTH-1:0] clr_only;

    always_comb begin
        both     = s & r;
        set_only = s & ~r;
        clr_only = r & ~s;

        q_d        = q_q;
        conflict_d = 1'b0;

        if (enable) begin
            // Unambiguous requests first; conflicting bits keep q_q here.
            q_d = (q_q | set_only) & ~clr_only;

            if (SET_WINS) begin
                q_d = q_d | both;
            end else if (RESET_WINS) begin
                q_d = q_d & ~both;
            end

            conflict_d = |both;
        end
    end

    // qbar has its own flop loaded from ~q_d so both outputs are registered
    // and switch on the same edge, never showing q == qbar.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= RESET_VALUE;
            qbar_q     <= ~RESET_VALUE;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            qbar_q     <= ~q_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign qbar     = qbar_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch.sv
// tb/tb_sr_latch.sv - self-checking bench for sr_latch

module tb_sr_latch;

    logic clk;
    logic rst, en, s, r;
    logic [0:0] q_m  [4];
    logic [0:0] qb_m [4];
    logic       c_m  [4];

    logic       wrst, wen;
    logic [3:0] ws, wr, wq, wqb;
    logic       wc;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One 1-bit instance per CONFLICT_MODE 0..3; mode 3 must act like mode 0.
    for (genvar k = 0; k < 4; k++) begin : g_m
        sr_latch #(.WIDTH(1), .CONFLICT_MODE(k), .RESET_VALUE(1'b0)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .enable   (en),
            .s        (s),
            .r        (r),
            .q        (q_m[k]),
            .qbar     (qb_m[k]),
            .conflict (c_m[k])
        );
    end

    sr_latch #(.WIDTH(4), .CONFLICT_MODE(1), .RESET_VALUE(4'b1010)) u_wide (
        .clk      (clk),
        .rst      (wrst),
        .enable   (wen),
        .s        (ws),
        .r        (wr),
        .q        (wq),
        .qbar     (wqb),
        .conflict (wc)
    );

    typedef struct {
        logic rst, en, s, r;
        logic q0, q1, q2, c;
    } vec_t;

    typedef struct {
        logic q0, q1, q2, c;
    } exp_t;

    typedef struct {
        logic [3:0] q;
        logic       c;
    } wexp_t;

    vec_t  tbl [$];
    exp_t  sb  [$];
    wexp_t wsb [$];

    task automatic add(input logic rs, input logic e, input logic ss, input logic rr,
                       input logic e0, input logic e1, input logic e2, input logic ec);
        vec_t v;
        v.rst = rs; v.en = e; v.s = ss; v.r = rr;
        v.q0 = e0; v.q1 = e1; v.q2 = e2; v.c = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%b required=%b", nm, idx, act, exp);
        end
    endtask

    // Pop one expectation and compare all four 1-bit instances against it.
    task automatic check_narrow(input int idx);
        exp_t e;
        logic eq;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty step=%0d actual=0 required=1", idx);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            eq = (k == 1) ? e.q1 : (k == 2) ? e.q2 : e.q0;
            chk($sformatf("q_mode%0d", k),    idx, {3'b000, q_m[k]},  {3'b000, eq});
            chk($sformatf("qbar_mode%0d", k), idx, {3'b000, qb_m[k]}, {3'b000, ~eq});
            chk($sformatf("conf_mode%0d", k), idx, {3'b000, c_m[k]},  {3'b000, e.c});
        end
    endtask

    task automatic check_wide(input int idx);
        wexp_t e;
        if (wsb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wide_scoreboard_empty step=%0d actual=0 required=1", idx);
            return;
        end
        e = wsb.pop_front();
        chk("wide_q",    idx, wq,  e.q);
        chk("wide_qbar", idx, wqb, ~e.q);
        chk("wide_conf", idx, {3'b000, wc}, {3'b000, e.c});
    endtask

    task automatic wide_step(input int idx, input logic rs, input logic e, input logic [3:0] ss,
                             input logic [3:0] rr, input logic [3:0] eq, input logic ec);
        wexp_t x;
        @(negedge clk);
        wrst = rs; wen = e; ws = ss; wr = rr;
        x.q = eq; x.c = ec;
        wsb.push_back(x);
        @(posedge clk);
        #1;
        check_wide(idx);
    endtask

    initial begin
        exp_t x;
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; s = 1'b0; r = 1'b0;
        wrst = 1'b1; wen = 1'b0; ws = 4'b0000; wr = 4'b0000;

        //   rst en  s  r   q0 q1 q2  c
        add(1, 0, 0, 0,   0, 0, 0, 0);  // reset
        add(1, 1, 1, 0,   0, 0, 0, 0);  // reset beats set
        add(0, 0, 0, 0,   0, 0, 0, 0);  // gated off
        add(0, 0, 0, 1,   0, 0, 0, 0);
        add(0, 0, 1, 0,   0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0);  // gated on
        add(0, 1, 0, 1,   0, 0, 0, 0);
        add(0, 1, 1, 0,   1, 1, 1, 0);
        add(0, 1, 0, 0,   1, 1, 1, 0);
        add(0, 0, 0, 1,   1, 1, 1, 0);  // hold while disabled x3
        add(0, 0, 0, 1,   1, 1, 1, 0);
        add(0, 0, 0, 1,   1, 1, 1, 0);
        add(0, 1, 0, 1,   0, 0, 0, 0);  // enable -> clear
        add(0, 1, 1, 0,   1, 1, 1, 0);
        add(0, 1, 1, 1,   1, 1, 0, 1);  // conflict from q=1
        add(0, 1, 0, 0,   1, 1, 0, 0);  // pulse is one cycle
        add(0, 1, 0, 1,   0, 0, 0, 0);
        add(0, 1, 1, 1,   0, 1, 0, 1);  // conflict from q=0
        add(0, 1, 1, 1,   0, 1, 0, 1);  // repeats while held
        add(0, 0, 1, 1,   0, 1, 0, 0);  // disabled: no conflict
        add(0, 1, 1, 0,   1, 1, 1, 0);
        add(1, 1, 1, 0,   0, 0, 0, 0);  // mid-sequence reset beats set
        add(1, 1, 1, 1,   0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; en = tbl[i].en; s = tbl[i].s; r = tbl[i].r;
            x.q0 = tbl[i].q0; x.q1 = tbl[i].q1; x.q2 = tbl[i].q2; x.c = tbl[i].c;
            sb.push_back(x);
            @(posedge clk);
            #1;
            check_narrow(i);
        end

        // Glitches between edges must not register: pulse set, then conflict,
        // and return to idle before the edge.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; s = 1'b1; r = 1'b0;
        #1 r = 1'b1;
        #1 s = 1'b0; r = 1'b0; en = 1'b0;
        x.q0 = 1'b0; x.q1 = 1'b0; x.q2 = 1'b0; x.c = 1'b0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_narrow(100);

        // Wide instance: WIDTH=4, RESET_VALUE=1010, set wins on conflict.
        wide_step(0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1010, 1'b0);
        wide_step(1, 1'b0, 1'b1, 4'b0001, 4'b1000, 4'b0011, 1'b0);
        wide_step(2, 1'b0, 1'b1, 4'b1100, 4'b0101, 4'b1110, 1'b1);
        wide_step(3, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1110, 1'b0);
        wide_step(4, 1'b0, 1'b1, 4'b0001, 4'b0110, 4'b1001, 1'b0);
        wide_step(5, 1'b1, 1'b1, 4'b0110, 4'b0000, 4'b1010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
